// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: line/address widths and the pmem arbiter enums.
package lc3b_types;

  localparam int unsigned PMEM_ADDR_W = 16;
  localparam int unsigned PMEM_LINE_W = 128;

  typedef logic [PMEM_ADDR_W-1:0] lc3b_pmem_addr;
  typedef logic [PMEM_LINE_W-1:0] lc3b_pmem_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } lc3b_arb_state;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } lc3b_arb_client;

endpackage

// File: rtl/pmem_arbiter_control.sv
// Arbiter FSM and tie-break logic. Round-robin ties when PMEM_ARB_RR_EN is
// defined, otherwise dcache always wins a tie.
module pmem_arbiter_control
  import lc3b_types::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           icache_req,
  input  logic           dcache_req,
  input  logic           pmem_resp,
  output lc3b_arb_state  state,
  output lc3b_arb_client grant
);

  lc3b_arb_state  next_state;
  lc3b_arb_client tie_winner;

`ifdef PMEM_ARB_RR_EN
  lc3b_arb_client last_grant;

  // Remember who won the most recent grant so the other side wins the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= ICACHE;
    end else if (state == IDLE && next_state == SERVE_I) begin
      last_grant <= ICACHE;
    end else if (state == IDLE && next_state == SERVE_D) begin
      last_grant <= DCACHE;
    end
  end

  assign tie_winner = (last_grant == ICACHE) ? DCACHE : ICACHE;
`else
  assign tie_winner = DCACHE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    grant      = (state == SERVE_I) ? ICACHE : DCACHE;
    case (state)
      IDLE: begin
        if (icache_req && dcache_req) begin
          next_state = (tie_winner == ICACHE) ? SERVE_I : SERVE_D;
        end else if (icache_req) begin
          next_state = SERVE_I;
        end else if (dcache_req) begin
          next_state = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          next_state = DONE;
        end
      end
      // One dead cycle lets the served cache drop its request before re-arbitration.
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/pmem_arbiter.sv
// icache/dcache to physical-memory arbiter. Optional round-robin tie-break
// is enabled with the PMEM_ARB_RR_EN macro.
module pmem_arbiter
  import lc3b_types::*;
(
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   icache_pmem_read,
  input  logic [PMEM_ADDR_W-1:0] icache_pmem_address,
  output logic                   icache_pmem_resp,
  output logic [PMEM_LINE_W-1:0] icache_pmem_rdata,

  input  logic                   dcache_pmem_read,
  input  logic                   dcache_pmem_write,
  input  logic [PMEM_ADDR_W-1:0] dcache_pmem_address,
  input  logic [PMEM_LINE_W-1:0] dcache_pmem_wdata,
  output logic                   dcache_pmem_resp,
  output logic [PMEM_LINE_W-1:0] dcache_pmem_rdata,

  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic [PMEM_ADDR_W-1:0] pmem_address,
  output logic [PMEM_LINE_W-1:0] pmem_wdata,
  input  logic                   pmem_resp,
  input  logic [PMEM_LINE_W-1:0] pmem_rdata
);

  lc3b_arb_state  state;
  lc3b_arb_client grant;
  logic           serving;

  pmem_arbiter_control u_control (
    .clk        (clk),
    .rst        (rst),
    .icache_req (icache_pmem_read),
    .dcache_req (dcache_pmem_read | dcache_pmem_write),
    .pmem_resp  (pmem_resp),
    .state      (state),
    .grant      (grant)
  );

  assign serving = (state == SERVE_I) || (state == SERVE_D);

  // Forward the granted client to memory and route the completion back to it only.
  always_comb begin
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    if (serving) begin
      if (grant == ICACHE) begin
        pmem_read        = 1'b1;
        pmem_address     = icache_pmem_address;
        icache_pmem_resp = pmem_resp;
      end else begin
        // Simultaneous read and write from dcache is illegal; the write wins.
        pmem_read        = dcache_pmem_read & ~dcache_pmem_write;
        pmem_write       = dcache_pmem_write;
        pmem_address     = dcache_pmem_address;
        pmem_wdata       = dcache_pmem_wdata;
        dcache_pmem_resp = pmem_resp;
      end
    end
  end

  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed, table-driven bench for pmem_arbiter; tie expectations follow PMEM_ARB_RR_EN.
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         icache_pmem_read;
  logic [15:0]  icache_pmem_address;
  logic         icache_pmem_resp;
  logic [127:0] icache_pmem_rdata;
  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [15:0]  dcache_pmem_address;
  logic [127:0] dcache_pmem_wdata;
  logic         dcache_pmem_resp;
  logic [127:0] dcache_pmem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  always #5 clk = ~clk;

  pmem_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_resp    (icache_pmem_resp),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_resp           (pmem_resp),
    .pmem_rdata          (pmem_rdata)
  );

  typedef struct {
    logic         rst;
    logic         ir;
    logic [15:0]  ia;
    logic         dr;
    logic         dw;
    logic [15:0]  da;
    logic [127:0] dwd;
    logic         pr;
    logic [127:0] prd;
    logic         e_ir;
    logic         e_dr;
    logic         e_rd;
    logic         e_wr;
    logic [15:0]  e_pa;
    logic [127:0] e_pwd;
  } vec_t;

  localparam logic [127:0] L1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] L2 = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
  localparam logic [127:0] L3 = 128'h5A5A_0F0F_F0F0_A5A5_1111_2222_3333_4444;
  localparam logic [127:0] A5 = {16{8'hA5}};

`ifdef PMEM_ARB_RR_EN
  localparam logic [2:0] WIN_I = 3'b010;
`else
  localparam logic [2:0] WIN_I = 3'b000;
`endif

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic ir, input logic [15:0] ia,
                     input logic dr, input logic dw, input logic [15:0] da,
                     input logic [127:0] dwd, input logic pr, input logic [127:0] prd,
                     input logic e_ir, input logic e_dr, input logic e_rd, input logic e_wr,
                     input logic [15:0] e_pa, input logic [127:0] e_pwd);
    vec_t v;
    v.rst = r;  v.ir = ir;  v.ia = ia;  v.dr = dr;  v.dw = dw;  v.da = da;
    v.dwd = dwd; v.pr = pr; v.prd = prd;
    v.e_ir = e_ir; v.e_dr = e_dr; v.e_rd = e_rd; v.e_wr = e_wr;
    v.e_pa = e_pa; v.e_pwd = e_pwd;
    vq.push_back(v);
  endtask

  task automatic idle_row(input logic pr, input logic [127:0] prd);
    add(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, '0, pr, prd, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, '0);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    int cnt_i;
    int cnt_d;
    int cnt_rd;
    logic ok;
    logic wi;

    rst = 1'b1;
    icache_pmem_read = 1'b0; icache_pmem_address = '0;
    dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
    dcache_pmem_address = '0; dcache_pmem_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    repeat (2) @(posedge clk);

    // Reset state
    idle_row(1'b0, '0);

    // Three back-to-back ties, both caches holding their requests throughout
    for (int r = 0; r < 3; r++) begin
      wi = WIN_I[r];
      add(1'b0, 1'b1, 16'h1000, 1'b1, 1'b0, 16'h2000, '0, 1'b0, '0,
          1'b0, 1'b0, 1'b0, 1'b0, 16'h0, '0);
      add(1'b0, 1'b1, 16'h1000, 1'b1, 1'b0, 16'h2000, '0, 1'b1, L2,
          wi, ~wi, 1'b1, 1'b0, wi ? 16'h1000 : 16'h2000, '0);
      add(1'b0, 1'b1, 16'h1000, 1'b1, 1'b0, 16'h2000, '0, 1'b0, '0,
          1'b0, 1'b0, 1'b0, 1'b0, 16'h0, '0);
    end
    idle_row(1'b0, '0);

    // icache read, memory latency 4; a stray resp lands in DONE
    add(1'b0, 1'b1, 16'h1230, 1'b0, 1'b0, 16'h0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, '0);
    for (int k = 0; k < 4; k++)
      add(1'b0, 1'b1, 16'h1230, 1'b0, 1'b0, 16'h0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1230, '0);
    add(1'b0, 1'b1, 16'h1230, 1'b0, 1'b0, 16'h0, '0, 1'b1, L1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1230, '0);
    add(1'b0, 1'b1, 16'h1230, 1'b0, 1'b0, 16'h0, '0, 1'b1, L2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, '0);
    idle_row(1'b0, '0);
    idle_row(1'b0, '0);

    // dcache write-back of an all-A5 line
    add(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h4560, A5, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, '0);
    for (int k = 0; k < 2; k++)
      add(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h4560, A5, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4560, A5);
    add(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h4560, A5, 1'b1, L3, 1'b0, 1'b1, 1'b0, 1'b1, 16'h4560, A5);
    add(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h4560, A5, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, '0);
    idle_row(1'b0, '0);

    // Stray resp in IDLE, then an illegal read+write request must be granted at once
    idle_row(1'b1, L1);
    add(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, L2, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, '0);
    add(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, L2, 1'b1, L1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, L2);
    idle_row(1'b0, '0);
    idle_row(1'b0, '0);

    // Reset two cycles into SERVE_D; late resp for the aborted transfer is dropped
    add(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h3330, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, '0);
    for (int k = 0; k < 2; k++)
      add(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h3330, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3330, '0);
    add(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h3330, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3330, '0);
    idle_row(1'b0, '0);
    idle_row(1'b0, '0);
    idle_row(1'b1, L3);
    idle_row(1'b0, '0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst                 = vq[i].rst;
      icache_pmem_read    = vq[i].ir;
      icache_pmem_address = vq[i].ia;
      dcache_pmem_read    = vq[i].dr;
      dcache_pmem_write   = vq[i].dw;
      dcache_pmem_address = vq[i].da;
      dcache_pmem_wdata   = vq[i].dwd;
      pmem_resp           = vq[i].pr;
      pmem_rdata          = vq[i].prd;
      #1;
      ok = (icache_pmem_resp === vq[i].e_ir) && (dcache_pmem_resp === vq[i].e_dr) &&
           (pmem_read === vq[i].e_rd) && (pmem_write === vq[i].e_wr) &&
           (pmem_address === vq[i].e_pa) && (pmem_wdata === vq[i].e_pwd) &&
           (icache_pmem_rdata === vq[i].prd) && (dcache_pmem_rdata === vq[i].prd);
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL vec%0d: got iresp=%b dresp=%b rd=%b wr=%b addr=%h wdata=%h irdata=%h drdata=%h; expected iresp=%b dresp=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h",
                 i, icache_pmem_resp, dcache_pmem_resp, pmem_read, pmem_write, pmem_address,
                 pmem_wdata, icache_pmem_rdata, dcache_pmem_rdata, vq[i].e_ir, vq[i].e_dr,
                 vq[i].e_rd, vq[i].e_wr, vq[i].e_pa, vq[i].e_pwd, vq[i].prd);
      end
    end

    // Hand-written: icache request held through DONE yields one transfer and one strobe
    @(negedge clk);
    rst = 1'b0; pmem_resp = 1'b0;
    icache_pmem_read = 1'b1; icache_pmem_address = 16'h0ABC;
    n = 0;
    @(negedge clk);
    #1;
    while (!pmem_read && n < 5) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("hs_grant_latency", 128'(n), 128'(0));
    chk("hs_addr", 128'(pmem_address), 128'(16'h0ABC));
    cnt_i = 0; cnt_d = 0; cnt_rd = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pmem_resp        = (k == 0);
      pmem_rdata       = L3;
      icache_pmem_read = (k <= 1);
      #1;
      if (icache_pmem_resp) cnt_i++;
      if (dcache_pmem_resp) cnt_d++;
      if (pmem_read) cnt_rd++;
    end
    chk("hs_iresp_count", 128'(cnt_i), 128'(1));
    chk("hs_dresp_count", 128'(cnt_d), 128'(0));
    chk("hs_read_cycles", 128'(cnt_rd), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
